// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Purpose : Shared constants and FSM encoding for the UART transmit scheduler.
// Revision: 1.0
// ============================================================================
package uart_pkg;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_STOP_BITS = 1;

    localparam logic UART_IDLE_LVL = 1'b1;

    typedef logic [1:0] uart_state_t;

    localparam uart_state_t ST_IDLE  = 2'd0;
    localparam uart_state_t ST_START = 2'd1;
    localparam uart_state_t ST_DATA  = 2'd2;
    localparam uart_state_t ST_STOP  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/uart_tx_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Purpose : Combinational round-robin pick, searching upward from ptr+1.
// Revision: 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any_req
);

    logic [ID_W-1:0] w_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        w_idx     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!any_req && req[w_idx]) begin
                any_req      = 1'b1;
                grant[w_idx] = 1'b1;
                grant_idx    = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_sched
// Purpose : Round-robin scheduler serialising bytes from NUM_REQ producers
//           onto one 8N1/8N2 UART line, sequencing the baud tick generator.
// Revision: 1.0
// ============================================================================
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int STOP_BITS = DEF_STOP_BITS,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      baud_tick,
    output logic                      baud_clr,
    output logic                      txd,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int SC_W  = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

    uart_state_t        state_q,    state_d;
    logic [DATA_W-1:0]  shift_q,    shift_d;
    logic [CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [SC_W-1:0]    stop_cnt_q, stop_cnt_d;
    logic [ID_W-1:0]    rr_q,       rr_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic               ready_en_q;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_gidx;
    logic               w_any;
    logic               w_idle;
    logic               w_hs;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_q),
        .grant     (w_grant),
        .grant_idx (w_gidx),
        .any_req   (w_any)
    );

    assign w_idle = (state_q == ST_IDLE);
    // ready_en_q keeps req_ready low while reset is asserted and for the
    // first cycle after release, so no producer sees an accept during reset.
    assign req_ready = w_grant & {NUM_REQ{w_idle & ready_en_q}};
    assign w_hs      = w_any & (|(req_valid & req_ready));
    assign baud_clr  = w_idle;
    assign busy      = ~w_idle;
    assign grant_id  = grant_id_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        rr_d       = rr_q;
        grant_id_d = grant_id_q;
        case (state_q)
            ST_IDLE: begin
                if (w_hs) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (w_grant[i]) begin
                            shift_d = req_data[i*DATA_W +: DATA_W];
                        end
                    end
                    rr_d       = w_gidx;
                    grant_id_d = w_gidx;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        stop_cnt_d = '0;
                        state_d    = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_q == SC_W'(STOP_BITS - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        txd = UART_IDLE_LVL;
        case (state_q)
            ST_START: txd = ~UART_IDLE_LVL;
            ST_DATA:  txd = shift_q[0];
            default:  txd = UART_IDLE_LVL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            rr_q       <= ID_W'(NUM_REQ - 1);
            grant_id_q <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            rr_q       <= rr_d;
            grant_id_q <= grant_id_d;
            ready_en_q <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one UART transmit line among NUM_REQ byte producers.
- Sequences the baud tick generator:
  - holds its count cleared while idle;
  - releases it at start-of-frame so every bit, including the start bit, lasts exactly one baud period.
- Serialises each granted byte as 8N1 (or 8N2), LSB first, on txd.
- Sits between the command/debug producers and the board TX pin.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, bits per character.
- STOP_BITS, 1, stop bits per frame (1 or 2).
- ID_W, $clog2(NUM_REQ), width of grant_id.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester byte-available flag.
- req_data  in  NUM_REQ*DATA_W  per-requester byte; slice i = [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot accept pulse.
- baud_tick  in  1  one-cycle pulse from the baud tick generator, once per bit period.
- baud_clr  out  1  high = generator count held at restart value.
- txd  out  1  serial output, idle high.
- busy  out  1  frame in progress.
- grant_id  out  ID_W  index of the most recently granted requester.

Behaviour:
- Reset values (asynchronous, take effect immediately on rst_n low):
  - txd=1, baud_clr=1, busy=0, req_ready=0, grant_id=0.
  - Internal state: FSM=IDLE, rr pointer=NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - Outputs: baud_clr=1, txd=1, busy=0.
  - baud_tick is ignored.
  - If any req_valid is set, winner g = first valid index searching upward from (rr+1) mod NUM_REQ.
  - req_ready[g]=1 combinationally in the same cycle; handshake = valid&ready.
  - On handshake:
    - latch req_data slice g into the shift register;
    - rr<=g, grant_id<=g;
    - next state START.
- START:
  - txd=0, baud_clr=0, busy=1.
  - On baud_tick -> DATA, bit counter=0.
- DATA:
  - txd = shift[0].
  - On baud_tick, shift right and increment the counter.
  - On the tick when the counter == DATA_W-1 -> STOP, stop counter=0.
- STOP:
  - txd=1.
  - On the STOP_BITS-th baud_tick -> IDLE.
- Latency:
  - Handshake at cycle t -> txd falls at t+1.
  - Frame = (1+DATA_W+STOP_BITS) baud periods.
  - At least one IDLE cycle separates frames, so baud_clr pulses high for ≥1 cycle between frames.
- req_ready is asserted only in IDLE, at most one bit high, never two cycles in a row for the same frame.
- Requester protocol:
  - data must stay stable while valid && !ready;
  - a requester may drop valid before it is granted; no frame results.
- Arbitration fairness: a continuously-valid requester waits at most NUM_REQ-1 frames.
- A baud_tick that coincides with the handshake cycle is ignored. The generator is still cleared in that cycle.
- Reset mid-frame: the line returns high immediately. The partial frame is abandoned and not retried; the requester already saw ready.
- No other inputs abort a frame.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (IDLE/START/DATA/STOP);
  - constant UART_IDLE_LVL=1'b1;
  - default DATA_W and STOP_BITS constants.
- One sub-module is natural: rr_arbiter (NUM_REQ request vector + pointer in, one-hot grant + index out, purely combinational).
- The FSM, shifter and counters stay in uart_tx_sched.

Test Plan:
- Single byte: tick every 16 clk; req_valid[0]=1, data 0xA5.
  - req_ready[0] pulses one cycle.
  - txd = 0,1,0,1,0,0,1,0,1,1, each bit 16 clk.
  - busy high for 160 clk; baud_clr low exactly during the frame.
- Contention: all four valid continuously, distinct bytes 0x10..0x13.
  - Grant order 0,1,2,3,0.
  - Each frame byte matches its requester.
  - Exactly one IDLE cycle between frames.
- Fairness: req2 held valid; req1 raised mid-frame of req2.
  - Next grant = 1 (search 3,0,1), then 2.
  - grant_id tracks the grants.
- STOP_BITS=2 build: one byte 0xFF -> frame of 11 baud periods, last two high.
  - Ticks injected during IDLE cause no txd change.
- Reset mid-DATA: rst_n low for 3 clk at bit 4.
  - txd=1 and busy=0 in the same cycle, req_ready=0.
  - After release, with req0 and req3 valid -> req0 granted first.
- Handshake/tick coincidence: baud_tick pulsed in the handshake cycle -> start bit still lasts a full period (no shortened bit).
